// File: rtl/port_relay_pkg.sv
// Shared defaults and helpers for the port_relay lane relay.
package port_relay_pkg;

    localparam int WIDTH_DEF    = 1;
    localparam int CHANNELS_DEF = 2;
    localparam int DEPTH_DEF    = 2;
    localparam int CNT_W_DEF    = 16;
    localparam int MAX_CH       = 64;

    function automatic int lane(input int c, input int w);
        return c * w;
    endfunction

    function automatic logic [31:0] popcount(input logic [MAX_CH-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Result clamps to the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int w);
        logic [32:0] s;
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        s = {1'b0, a} + {1'b0, b};
        return (s > m) ? m[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/port_relay_stage.sv
// One relay pipeline register: clear beats enable.
module port_relay_stage #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/port_relay.sv
// Multi-lane relay: tie-off select, retiming pipeline or bypass,
// plus per-lane change pulses and a saturating change counter.
module port_relay
    import port_relay_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_hold,
    input  logic                      i_bypass,
    input  logic [CHANNELS-1:0]       i_tie_en,
    input  logic [CHANNELS*WIDTH-1:0] i_tie_val,
    output logic [CHANNELS*WIDTH-1:0] o_data,
    output logic                      o_valid,
    output logic [CHANNELS-1:0]       o_chg,
    output logic [CNT_W-1:0]          o_chg_count
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int SW = DW + 1;

    logic [DW-1:0]          w_sel;
    logic [DEPTH:0][SW-1:0] w_stg;
    logic                   w_clr;
    logic [CHANNELS-1:0]    w_diff;
    logic [31:0]            w_sum;

    logic [DW-1:0]          r_last;
    logic [CHANNELS-1:0]    r_chg;
    logic [CNT_W-1:0]       r_cnt;

    always_comb begin
        w_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sel[lane(c, WIDTH) +: WIDTH] = i_tie_en[c]
                ? i_tie_val[lane(c, WIDTH) +: WIDTH]
                : i_data[lane(c, WIDTH) +: WIDTH];
        end
    end

    // Bypass flushes the pipeline so no stale word leaks out later.
    assign w_clr    = i_rst | (i_bypass & ~i_hold);
    assign w_stg[0] = {w_sel, i_valid & ~i_hold};

    for (genvar g = 0; g < DEPTH; g++) begin : g_stg
        port_relay_stage #(
            .W (SW)
        ) u_stg (
            .i_clk (i_clk),
            .i_en  (~i_hold),
            .i_clr (w_clr),
            .i_d   (w_stg[g]),
            .o_q   (w_stg[g+1])
        );
    end

    assign o_ready = ~i_hold;
    assign o_data  = i_bypass ? w_sel : w_stg[DEPTH][SW-1:1];
    assign o_valid = i_bypass ? (i_valid & ~i_hold) : w_stg[DEPTH][0];

    always_comb begin
        w_diff = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_diff[c] = o_data[lane(c, WIDTH) +: WIDTH]
                     != r_last[lane(c, WIDTH) +: WIDTH];
        end
    end

    assign w_sum = sat_add(32'(r_cnt), popcount(MAX_CH'(w_diff)), CNT_W);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= '0;
            r_chg  <= '0;
            r_cnt  <= '0;
        end else if (i_hold) begin
            r_chg  <= '0;
        end else if (o_valid) begin
            r_chg  <= w_diff;
            r_last <= o_data;
            r_cnt  <= w_sum[CNT_W-1:0];
        end else begin
            r_chg  <= '0;
        end
    end

    assign o_chg       = i_hold ? '0 : r_chg;
    assign o_chg_count = r_cnt;

endmodule

// File: tb/tb_port_relay.sv
// Scoreboard bench for port_relay (3-bit lanes, 2 lanes, depth 2,
// 3-bit change counter so saturation is reachable).
module tb_port_relay;

    localparam int WIDTH    = 3;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 2;
    localparam int CNT_W    = 3;
    localparam int DW       = WIDTH * CHANNELS;

    logic                clk = 1'b0;
    logic                i_rst;
    logic [DW-1:0]       i_data;
    logic                i_valid;
    logic                o_ready;
    logic                i_hold;
    logic                i_bypass;
    logic [CHANNELS-1:0] i_tie_en;
    logic [DW-1:0]       i_tie_val;
    logic [DW-1:0]       o_data;
    logic                o_valid;
    logic [CHANNELS-1:0] o_chg;
    logic [CNT_W-1:0]    o_chg_count;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];

    port_relay #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_hold      (i_hold),
        .i_bypass    (i_bypass),
        .i_tie_en    (i_tie_en),
        .i_tie_val   (i_tie_val),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_chg       (o_chg),
        .o_chg_count (o_chg_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [DW-1:0] d, input bit push,
                         input logic [DW-1:0] e);
        i_valid = 1'b1;
        i_data  = d;
        if (push) exp_q.push_back(e);
    endtask

    task automatic do_reset();
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_hold   = 1'b0;
        i_bypass = 1'b0;
        i_tie_en = '0;
        i_data   = '0;
        tick();
        i_rst    = 1'b0;
    endtask

    // Monitor: every transferred output word must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!i_rst && o_valid && !i_hold) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             o_data);
                end else begin
                    chk("out_word", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] w [6];
        int            cnt_exp [9];
        logic [2:0]    l0;

        i_rst     = 1'b1;
        i_data    = '0;
        i_valid   = 1'b0;
        i_hold    = 1'b0;
        i_bypass  = 1'b0;
        i_tie_en  = '0;
        i_tie_val = '0;
        tick();
        tick();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_chg", 32'(o_chg), 0);
        chk("rst_cnt", 32'(o_chg_count), 0);
        chk("rst_ready", 32'(o_ready), 1);
        i_hold = 1'b1;
        #1;
        chk("rst_hold_ready", 32'(o_ready), 0);
        i_hold = 1'b0;
        i_rst  = 1'b0;

        // Bypass with lane 0 tied low.
        i_bypass  = 1'b1;
        i_tie_en  = 2'b01;
        i_tie_val = '0;
        drive(6'o17, 1, 6'o10);
        tick();
        chk("byp_chg1", 32'(o_chg), 32'b10);
        chk("byp_cnt1", 32'(o_chg_count), 1);
        drive(6'o05, 1, 6'o00);
        tick();
        chk("byp_chg2", 32'(o_chg), 32'b10);
        chk("byp_cnt2", 32'(o_chg_count), 2);
        i_valid = 1'b0;
        tick();
        chk("byp_chg3", 32'(o_chg), 0);
        chk("byp_cnt3", 32'(o_chg_count), 2);

        // Registered streaming, latency and counter reaching its max.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                chk("lat_valid", 32'(o_valid), 1);
                chk("lat_data", 32'(o_data), 32'(i - 2));
            end
            drive(DW'(i), 1, DW'(i));
            tick();
        end
        i_valid = 1'b0;
        tick();
        tick();
        chk("stream_chg", 32'(o_chg), 32'b01);
        chk("stream_cnt", 32'(o_chg_count), 7);

        // Hold mid-stream.
        do_reset();
        w[0] = 6'o11; w[1] = 6'o22; w[2] = 6'o33;
        w[3] = 6'o44; w[4] = 6'o55; w[5] = 6'o66;
        drive(w[0], 1, w[0]);
        tick();
        drive(w[1], 1, w[1]);
        tick();
        drive(w[2], 1, w[2]);
        tick();
        chk("pre_hold_chg", 32'(o_chg), 32'b11);
        chk("pre_hold_cnt", 32'(o_chg_count), 2);
        i_hold = 1'b1;
        drive(6'o77, 0, '0);
        #1;
        chk("hold_ready", 32'(o_ready), 0);
        tick();
        chk("hold_data1", 32'(o_data), 32'(w[1]));
        chk("hold_valid1", 32'(o_valid), 1);
        chk("hold_chg1", 32'(o_chg), 0);
        chk("hold_cnt1", 32'(o_chg_count), 2);
        tick();
        chk("hold_data2", 32'(o_data), 32'(w[1]));
        chk("hold_chg2", 32'(o_chg), 0);
        tick();
        chk("hold_chg3", 32'(o_chg), 0);
        chk("hold_cnt3", 32'(o_chg_count), 2);
        i_hold = 1'b0;
        drive(w[3], 1, w[3]);
        tick();
        chk("post_hold_chg", 32'(o_chg), 32'b11);
        chk("post_hold_cnt", 32'(o_chg_count), 4);
        drive(w[4], 1, w[4]);
        tick();
        drive(w[5], 1, w[5]);
        tick();
        i_valid = 1'b0;
        repeat (4) tick();

        // Bypass entry drops in-flight words; return refills the pipe.
        do_reset();
        drive(6'o12, 0, '0);
        tick();
        drive(6'o34, 0, '0);
        tick();
        i_bypass = 1'b1;
        drive(6'o56, 1, 6'o56);
        tick();
        chk("bsw_chg", 32'(o_chg), 32'b11);
        chk("bsw_cnt", 32'(o_chg_count), 2);
        i_bypass = 1'b0;
        drive(6'o70, 1, 6'o70);
        #1;
        chk("ret_valid0", 32'(o_valid), 0);
        tick();
        chk("ret_valid1", 32'(o_valid), 0);
        chk("ret_chg", 32'(o_chg), 0);
        chk("ret_cnt", 32'(o_chg_count), 2);
        i_valid = 1'b0;
        tick();
        chk("ret_valid2", 32'(o_valid), 1);
        chk("ret_data", 32'(o_data), 32'(6'o70));
        tick();
        chk("ret_chg2", 32'(o_chg), 32'b11);
        chk("ret_cnt2", 32'(o_chg_count), 4);

        // Reset while full (and held) discards everything.
        drive(6'o01, 0, '0);
        tick();
        drive(6'o02, 0, '0);
        tick();
        drive(6'o03, 0, '0);
        i_rst  = 1'b1;
        i_hold = 1'b1;
        tick();
        i_rst  = 1'b0;
        i_hold = 1'b0;
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_data", 32'(o_data), 0);
        chk("mid_rst_chg", 32'(o_chg), 0);
        chk("mid_rst_cnt", 32'(o_chg_count), 0);
        drive(6'o45, 1, 6'o45);
        tick();
        i_valid = 1'b0;
        chk("rst_refill0", 32'(o_valid), 0);
        tick();
        chk("rst_refill1", 32'(o_valid), 1);
        chk("rst_refill_data", 32'(o_data), 32'(6'o45));
        tick();

        // Saturation: lane 1 tied to 5, lane 0 toggling in bypass.
        do_reset();
        i_bypass  = 1'b1;
        i_tie_en  = 2'b10;
        i_tie_val = 6'o50;
        cnt_exp = '{2, 3, 4, 5, 6, 7, 7, 7, 7};
        for (int k = 0; k < 9; k++) begin
            l0 = (k % 2 == 0) ? 3'd7 : 3'd0;
            drive({3'd2, l0}, 1, {3'd5, l0});
            tick();
            chk("sat_cnt", 32'(o_chg_count), 32'(cnt_exp[k]));
        end
        i_valid  = 1'b0;
        i_bypass = 1'b0;
        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
